instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Write-side counterpart of the instruction memory. It receives a byte stream (e.g. from a UART or debug port) and assembles big-endian 32-bit instruction words. It writes those words into consecutive instruction-memory locations starting at a programmed base address. While a load is in progress it holds the CPU pipeline in stall, so the processor never fetches a partially written program.

Parameters:
ADDR_W, 16, width of instruction address (matches 16-bit pc)
DEPTH, 1024, number of 32-bit words in instruction memory
DATA_W, 32, instruction word width (fixed at 4 bytes)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load
base_addr  input  ADDR_W  first word address to write; sampled on accepted start
word_count  input  ADDR_W  number of words to load; sampled on accepted start
byte_valid  input  1  byte_data is valid
byte_data  input  8  incoming byte, MSB-first within a word
byte_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_W  instruction memory write address
imem_wdata  output  DATA_W  instruction word to write
cpu_hold  output  1  stall request to pipeline/PC
busy  output  1  load in progress
done  output  1  one-cycle pulse, load complete
error  output  1  one-cycle pulse, request rejected (range overflow)

Behaviour:
- Reset is asynchronous and active-low: clk / rst_n. While rst_n=0:
  - all outputs are 0 and state=IDLE;
  - the internal word register, byte index, address and remaining counter are cleared.
- Reset mid-load abandons the load. No partial word is written, and cpu_hold drops immediately.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready=0, cpu_hold=0, busy=0. On start=1:
  - word_count=0 -> done pulses next cycle; stay IDLE; nothing written.
  - base_addr+word_count > DEPTH, computed at ADDR_W+1 bits so there is no wrap -> error pulses next cycle; stay IDLE; nothing written.
  - otherwise -> latch base_addr into cur_addr and word_count into remaining, clear byte index, go COLLECT. cpu_hold=1 and busy=1 from the next cycle.
- COLLECT: byte_ready=1.
  - Each cycle with byte_valid&&byte_ready: word <= {word[23:0], byte_data}; idx++.
  - On the 4th accepted byte (idx=3) go WRITE.
  - byte_valid=0 simply waits; there is no timeout.
- WRITE: byte_ready=0. For exactly one cycle: imem_we=1, imem_addr=cur_addr, imem_wdata=assembled word. Then cur_addr++, remaining--, idx=0.
  - remaining reaches 0 -> DONE; otherwise -> COLLECT.
- DONE: done=1 for one cycle, busy=0, cpu_hold=1 this cycle; then IDLE, with cpu_hold=0 from the following cycle.
- Latency: 4th byte accepted at edge N -> imem_we high in cycle N+1. Steady-state throughput is 1 word per 5 cycles with byte_valid held high.
- imem_addr and imem_wdata are registered. They hold their last value when imem_we=0.
- start while busy (COLLECT/WRITE/DONE) is ignored: no error, parameters unchanged.
- start coincident with a byte_valid in IDLE: the byte is not accepted (byte_ready=0).
- Last writable address is DEPTH-1. Base=DEPTH-1, count=1 is legal. Base=DEPTH-1, count=2 -> error.
- All control outputs are Moore (state-decoded, registered); no combinational path from inputs to outputs.

Test Plan:
1. Single word: start, base=0, count=1; bytes 0x19,0x96,0xC0,0x4F back-to-back -> imem_we one cycle after 4th byte, addr=0, wdata=0x1996C04F; done pulse; cpu_hold low 2 cycles after write.
2. Multi-word with gaps: base=0x0010, count=3; words 0xF20538DC, 0x00000000, 0x8B65A743 with random byte_valid gaps -> exactly 3 writes at 0x10/0x11/0x12 with matching data; no extra imem_we; busy high throughout.
3. Range checks: base=1023, count=1 -> one write at 1023 and done. base=1023, count=2 -> error pulse, no imem_we, cpu_hold stays 0. count=0 -> done pulse only.
4. Start while busy: second start with base=0x200 during COLLECT -> ignored; writes continue at the original addresses; no error.
5. Reset mid-load: assert rst_n=0 after 2 bytes of word 2 -> all outputs 0 asynchronously. After release, a fresh load of 0xE7298BE4 at base 5 writes correctly, with no residue from the old bytes.
6. Backpressure: byte_valid held high continuously -> byte_ready low during WRITE, with no byte lost or duplicated (5 cycles per word).

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
//
// Bundles the control, byte-stream and instruction-memory write signals of
// the instruction memory loader into one interface.
//
//   start       request to begin a load (single cycle)
//   base_addr   first word address to write, sampled on an accepted start
//   word_count  number of words to load, sampled on an accepted start
//   byte_valid  byte_data carries a valid byte
//   byte_data   incoming byte, most significant byte of each word first
//   byte_ready  loader accepts a byte this cycle
//   imem_we     instruction memory write enable
//   imem_addr   instruction memory write address
//   imem_wdata  instruction word being written
//   cpu_hold    stall request to the pipeline / PC
//   busy        load in progress
//   done        one-cycle pulse when a load completes
//   error       one-cycle pulse when a request is rejected
//
// Modports:
//   master  the side that issues requests and supplies bytes
//   slave   the loader itself
// ---------------------------------------------------------------------------
interface instr_mem_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start,
    output base_addr,
    output word_count,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  cpu_hold,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  base_addr,
    input  word_count,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output cpu_hold,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Write side of the instruction memory. Assembles a byte stream into
// big-endian 32-bit words and writes them to consecutive instruction memory
// locations starting at a programmed base address. The CPU pipeline is held
// in stall for the whole load so a partially written program is never
// fetched.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; abandons any load in progress
//   bus    instr_mem_loader_if.slave
//            inputs : start, base_addr, word_count, byte_valid, byte_data
//            outputs: byte_ready, imem_we, imem_addr, imem_wdata,
//                     cpu_hold, busy, done, error
//
// All outputs come straight from flops; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_mem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // The range check is done one bit wider than the address so that a base
  // near the top of the address space cannot wrap around and pass.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q,      state_d;
  logic [ADDR_W-1:0] cur_addr_q,   cur_addr_d;
  logic [ADDR_W-1:0] remaining_q,  remaining_d;
  logic [1:0]        idx_q,        idx_d;
  logic [DATA_W-1:0] word_q,       word_d;

  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q,    imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              cpu_hold_q,   cpu_hold_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic              error_q,      error_d;

  logic [ADDR_W:0]   range_end;
  logic              byte_accept;
  logic [DATA_W-1:0] shifted_word;

  assign range_end    = {1'b0, bus.base_addr} + {1'b0, bus.word_count};
  // byte_ready_q is only ever high in COLLECT, so it doubles as the
  // "accepting bytes" qualifier.
  assign byte_accept  = byte_ready_q && bus.byte_valid;
  assign shifted_word = {word_q[DATA_W-9:0], bus.byte_data};

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    word_d       = word_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = 1'b0;
    error_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.word_count == '0) begin
            done_d = 1'b1;
          end else if (range_end > DEPTH_EXT) begin
            error_d = 1'b1;
          end else begin
            cur_addr_d  = bus.base_addr;
            remaining_d = bus.word_count;
            idx_d       = 2'd0;
            state_d     = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (byte_accept) begin
          word_d = shifted_word;
          idx_d  = idx_q + 2'd1;
          // Address and data are loaded here so they are already stable in
          // the single WRITE cycle that follows the fourth byte.
          if (idx_q == 2'd3) begin
            imem_addr_d  = cur_addr_q;
            imem_wdata_d = shifted_word;
            state_d      = WRITE;
          end
        end
      end

      WRITE: begin
        cur_addr_d  = cur_addr_q + ADDR_ONE;
        remaining_d = remaining_q - ADDR_ONE;
        idx_d       = 2'd0;
        state_d     = (remaining_q == ADDR_ONE) ? DONE : COLLECT;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Control outputs are decoded from the next state so that they are
    // registered yet line up with the state they describe.
    byte_ready_d = (state_d == COLLECT);
    imem_we_d    = (state_d == WRITE);
    busy_d       = (state_d == COLLECT) || (state_d == WRITE);
    cpu_hold_d   = (state_d != IDLE);
    done_d       = done_d || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Self-checking bench for instr_mem_loader. A transaction-level model turns
// each load request into the list of memory writes it must produce; a
// compare process checks every write and pulse against that list, and the
// directed tests pin cycle timing with literal expectations.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_mem_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int write_count  = 0;
  int done_seen    = 0;
  int error_seen   = 0;
  int we_cycles[$];
  wr_t exp_q[$];
  wr_t cmp_e;
  logic [DATA_W-1:0] words[$];
  logic prev_done  = 1'b0;
  logic prev_error = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: what a request must do, from the request alone.
  // 0 = done pulse without writes, 1 = rejected, 2 = load (writes queued).
  function automatic int model_load(input int base, input int count);
    if (count == 0) return 0;
    if (base + count > DEPTH) return 1;
    for (int i = 0; i < count; i++) begin
      wr_t w;
      w.addr = ADDR_W'(base + i);
      w.data = words[i];
      exp_q.push_back(w);
    end
    return 2;
  endfunction

  // Compare process: every write, done and error pulse against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_we) begin
        write_count++;
        we_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_write: got write addr 0x%0h data 0x%0h, expected no write",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          cmp_e = exp_q.pop_front();
          checkOutput("write_addr", bus.imem_addr, cmp_e.addr);
          checkOutput("write_data", bus.imem_wdata, cmp_e.data);
        end
        checkOutput("hold_during_write", bus.cpu_hold, 1);
        checkOutput("ready_low_in_write", bus.byte_ready, 0);
      end
      if (bus.done) begin
        done_seen++;
        checkOutput("done_single_cycle", prev_done, 0);
      end
      if (bus.error) begin
        error_seen++;
        checkOutput("error_single_cycle", prev_error, 0);
        checkOutput("no_hold_on_error", bus.cpu_hold, 0);
      end
      if (bus.byte_ready) checkOutput("busy_while_ready", bus.busy, 1);
      prev_done  = bus.done;
      prev_error = bus.error;
    end else begin
      prev_done  = 1'b0;
      prev_error = 1'b0;
    end
  end

  // All driving tasks start and end just after a rising edge.
  task automatic pulse_start(input int base, input int count);
    bus.start      = 1'b1;
    bus.base_addr  = ADDR_W'(base);
    bus.word_count = ADDR_W'(count);
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.base_addr = 16'hBEEF;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    forever begin
      @(negedge clk);
      if (bus.byte_ready) break;
      n++;
      if (n > 20) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL byte_handshake: byte_ready 0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit check_busy);
    bus.byte_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (check_busy) checkOutput("busy_in_gap", bus.busy, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    bus.byte_valid = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL done_timeout: done 0 for %0d cycles, expected 1", budget);
    end
    @(posedge clk); #1;
  endtask

  // Runs a complete load with an optional gap before every byte.
  task automatic applyStimulus(input int base, input int count, input int gap);
    int outcome;
    outcome = model_load(base, count);
    pulse_start(base, count);
    if (outcome == 2) begin
      for (int w = 0; w < count; w++) begin
        for (int b = 3; b >= 0; b--) begin
          if (gap > 0) idle(gap, 1'b1);
          send_byte(words[w][b*8 +: 8]);
        end
      end
      wait_done(40 * count + 20);
    end
  endtask

  int outcome;
  int w0, d0, e0;
  int gaps[12] = '{1, 0, 2, 0, 0, 3, 0, 1, 2, 0, 0, 1};

  initial begin
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #11;
    checkOutput("reset_ctrl", {bus.byte_ready, bus.imem_we, bus.cpu_hold,
                               bus.busy, bus.done, bus.error}, 0);
    checkOutput("reset_addr", bus.imem_addr, 0);
    checkOutput("reset_wdata", bus.imem_wdata, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. Single word, back-to-back bytes
    $display("[TB] single word");
    words = {};
    words.push_back(32'h1996C04F);
    outcome = model_load(0, 1);
    checkOutput("t1_model_outcome", outcome, 2);
    pulse_start(0, 1);
    @(negedge clk);
    checkOutput("t1_busy_after_start", bus.busy, 1);
    checkOutput("t1_hold_after_start", bus.cpu_hold, 1);
    checkOutput("t1_ready_after_start", bus.byte_ready, 1);
    @(posedge clk); #1;
    send_byte(8'h19);
    send_byte(8'h96);
    send_byte(8'hC0);
    send_byte(8'h4F);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_we_latency", bus.imem_we, 1);
    checkOutput("t1_wdata_literal", bus.imem_wdata, 32'h1996C04F);
    checkOutput("t1_addr_literal", bus.imem_addr, 0);
    @(negedge clk);
    checkOutput("t1_done_pulse", bus.done, 1);
    checkOutput("t1_busy_in_done", bus.busy, 0);
    checkOutput("t1_hold_in_done", bus.cpu_hold, 1);
    @(negedge clk);
    checkOutput("t1_hold_released", bus.cpu_hold, 0);
    checkOutput("t1_we_held_low", bus.imem_we, 0);
    @(posedge clk); #1;

    // 2. Multi-word with gaps
    $display("[TB] multi word with gaps");
    words = {};
    words.push_back(32'hF20538DC);
    words.push_back(32'h00000000);
    words.push_back(32'h8B65A743);
    w0 = write_count;
    outcome = model_load(16'h0010, 3);
    checkOutput("t2_model_outcome", outcome, 2);
    checkOutput("t2_model_addr2", exp_q[2].addr, 16'h0012);
    pulse_start(16'h0010, 3);
    for (int i = 0; i < 12; i++) begin
      idle(gaps[i], 1'b1);
      send_byte(words[i/4][(3 - i%4)*8 +: 8]);
    end
    wait_done(60);
    checkOutput("t2_write_count", write_count - w0, 3);
    checkOutput("t2_all_writes_seen", exp_q.size(), 0);

    // 3. Range checks
    $display("[TB] range checks");
    words = {};
    words.push_back(32'h0BADF00D);
    w0 = write_count;
    d0 = done_seen;
    applyStimulus(1023, 1, 0);
    checkOutput("t3_top_write_count", write_count - w0, 1);
    checkOutput("t3_top_done", done_seen - d0, 1);

    w0 = write_count;
    e0 = error_seen;
    outcome = model_load(1023, 2);
    checkOutput("t3_model_overflow", outcome, 1);
    pulse_start(1023, 2);
    @(negedge clk);
    checkOutput("t3_error_pulse", bus.error, 1);
    checkOutput("t3_hold_on_error", bus.cpu_hold, 0);
    checkOutput("t3_busy_on_error", bus.busy, 0);
    idle(3, 1'b0);
    checkOutput("t3_overflow_no_write", write_count - w0, 0);
    checkOutput("t3_overflow_errors", error_seen - e0, 1);
    checkOutput("t3_addr_held", bus.imem_addr, 16'd1023);

    e0 = error_seen;
    outcome = model_load(16'hFFFF, 2);
    checkOutput("t3_model_wrap", outcome, 1);
    pulse_start(16'hFFFF, 2);
    idle(3, 1'b0);
    checkOutput("t3_wrap_errors", error_seen - e0, 1);

    w0 = write_count;
    d0 = done_seen;
    outcome = model_load(7, 0);
    checkOutput("t3_model_zero", outcome, 0);
    pulse_start(7, 0);
    @(negedge clk);
    checkOutput("t3_zero_done", bus.done, 1);
    checkOutput("t3_zero_hold", bus.cpu_hold, 0);
    idle(3, 1'b0);
    checkOutput("t3_zero_no_write", write_count - w0, 0);
    checkOutput("t3_zero_done_count", done_seen - d0, 1);

    // 4. Start while busy is ignored
    $display("[TB] start while busy");
    words = {};
    words.push_back(32'hCAFE0123);
    words.push_back(32'h4567ABCD);
    w0 = write_count;
    e0 = error_seen;
    void'(model_load(16'h0040, 2));
    pulse_start(16'h0040, 2);
    send_byte(8'hCA);
    send_byte(8'hFE);
    bus.byte_valid = 1'b0;
    pulse_start(16'h0200, 5);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h45);
    send_byte(8'h67);
    send_byte(8'hAB);
    send_byte(8'hCD);
    wait_done(40);
    idle(6, 1'b0);
    checkOutput("t4_write_count", write_count - w0, 2);
    checkOutput("t4_no_error", error_seen - e0, 0);
    checkOutput("t4_all_writes_seen", exp_q.size(), 0);

    // 5. Reset mid-load, then a clean load
    $display("[TB] reset mid-load");
    words = {};
    words.push_back(32'hA1B2C3D4);
    words.push_back(32'h55667788);
    void'(model_load(16'h0030, 2));
    pulse_start(16'h0030, 2);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    send_byte(8'h55);
    send_byte(8'h66);
    bus.byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_ctrl", {bus.byte_ready, bus.imem_we, bus.cpu_hold,
                                  bus.busy, bus.done, bus.error}, 0);
    checkOutput("t5_async_addr", bus.imem_addr, 0);
    checkOutput("t5_async_wdata", bus.imem_wdata, 0);
    checkOutput("t5_word2_pending", exp_q.size(), 1);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    words = {};
    words.push_back(32'hE7298BE4);
    w0 = write_count;
    applyStimulus(5, 1, 0);
    checkOutput("t5_fresh_write_count", write_count - w0, 1);
    checkOutput("t5_fresh_write_seen", exp_q.size(), 0);

    // 6. Continuous byte_valid, start coincident with a byte
    $display("[TB] backpressure");
    words = {};
    words.push_back(32'h11223344);
    words.push_back(32'h55667788);
    words.push_back(32'h99AABBCC);
    w0 = write_count;
    we_cycles.delete();
    void'(model_load(16'h0100, 3));
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    pulse_start(16'h0100, 3);
    for (int i = 0; i < 12; i++) send_byte(words[i/4][(3 - i%4)*8 +: 8]);
    wait_done(40);
    checkOutput("t6_write_count", write_count - w0, 3);
    checkOutput("t6_all_writes_seen", exp_q.size(), 0);
    if (we_cycles.size() == 3) begin
      checkOutput("t6_word_period_1", we_cycles[1] - we_cycles[0], 5);
      checkOutput("t6_word_period_2", we_cycles[2] - we_cycles[1], 5);
    end else begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL t6_we_cycles: got %0d write cycles, expected 3", we_cycles.size());
    end

    idle(2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
